binary_to_bcd_converter: RTL and testbench

Sequential double-dabble converter that turns an unsigned binary value into packed BCD, one decimal digit per nibble.
Sits directly upstream of the multiplexed seven-segment controller: its bcd output drives that controller's data bus (4 bits per digit, digit 0 in bits [3:0]).
Uses a valid/ready input handshake and a one-cycle result strobe.
The output register holds the last result, so the display stays stable between conversions.

---
 rtl/binary_to_bcd_converter_if.sv | 34 +++
 rtl/binary_to_bcd_converter.sv | 124 ++++++++++++
 tb/tb_binary_to_bcd_converter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/binary_to_bcd_converter_if.sv
// Handshake and result bus for the binary-to-BCD converter.
// master drives value/inputValid, slave returns the BCD result.
interface binary_to_bcd_converter_if #(
    parameter int INPUT_WIDTH = 27,
    parameter int DIGITS      = 8
);
    logic [INPUT_WIDTH-1:0] value;
    logic                   inputValid;
    logic                   inputReady;
    logic [DIGITS*4-1:0]    bcd;
    logic                   outputValid;
    logic                   overflow;
    logic                   negative;

    modport master (
        output value,
        output inputValid,
        input  inputReady,
        input  bcd,
        input  outputValid,
        input  overflow,
        input  negative
    );

    modport slave (
        input  value,
        input  inputValid,
        output inputReady,
        output bcd,
        output outputValid,
        output overflow,
        output negative
    );
endinterface

// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble binary to packed BCD converter.
// Define BCD_SIGNED_INPUT_EN for two's complement input with sign output.
module binary_to_bcd_converter #(
    parameter int INPUT_WIDTH = 27,
    parameter int DIGITS      = 8
) (
    input logic                   clock,
    input logic                   reset,
    binary_to_bcd_converter_if.slave bus
);
    localparam int DW = DIGITS * 4;
    localparam int CW = $clog2(INPUT_WIDTH);

    function automatic logic [63:0] max_value(input int d);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < d; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    localparam logic [63:0] MAX_RESULT = max_value(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                 state;
    logic [INPUT_WIDTH-1:0] binary;
    logic [DW-1:0]          scratch;
    logic [DW-1:0]          adjusted;
    logic [CW-1:0]          count;
    logic                   overflowPending;
    logic [DW-1:0]          bcdReg;
    logic                   outputValidReg;
    logic                   overflowReg;
    logic [INPUT_WIDTH-1:0] magnitude;
    logic                   accept;

    assign accept = bus.inputValid && (state == IDLE);

`ifdef BCD_SIGNED_INPUT_EN
    logic signPending;
    logic negativeReg;

    // Two's complement magnitude; most-negative maps to 2^(W-1).
    always_comb begin
        magnitude = bus.value;
        if (bus.value[INPUT_WIDTH-1]) magnitude = -bus.value;
    end

    // Sign travels with the conversion and lands on the DONE edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            signPending <= 1'b0;
            negativeReg <= 1'b0;
        end else begin
            if (accept) signPending <= bus.value[INPUT_WIDTH-1];
            if (state == DONE) negativeReg <= signPending;
        end
    end

    assign bus.negative = negativeReg;
`else
    assign magnitude    = bus.value;
    assign bus.negative = 1'b0;
`endif

    // Add-3 correction on every nibble before the shift.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5)
                adjusted[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
        end
    end

    // Conversion FSM with registered result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            binary          <= '0;
            scratch         <= '0;
            count           <= '0;
            overflowPending <= 1'b0;
            bcdReg          <= '0;
            outputValidReg  <= 1'b0;
            overflowReg     <= 1'b0;
        end else begin
            outputValidReg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.inputValid) begin
                        binary          <= magnitude;
                        scratch         <= '0;
                        count           <= CW'(INPUT_WIDTH - 1);
                        overflowPending <= 64'(magnitude) > MAX_RESULT;
                        state           <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {adjusted[DW-2:0], binary[INPUT_WIDTH-1]};
                    binary  <= {binary[INPUT_WIDTH-2:0], 1'b0};
                    if (count == '0) state <= DONE;
                    else count <= count - 1'b1;
                end
                DONE: begin
                    bcdReg         <= overflowPending ? {DIGITS{4'h9}}
                                                      : scratch;
                    overflowReg    <= overflowPending;
                    outputValidReg <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.inputReady  = (state == IDLE);
    assign bus.bcd         = bcdReg;
    assign bus.outputValid = outputValidReg;
    assign bus.overflow    = overflowReg;
endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Directed self-checking bench for binary_to_bcd_converter.
// Signed checks run only when BCD_SIGNED_INPUT_EN is defined.
module tb_binary_to_bcd_converter;
`ifdef BCD_SIGNED_INPUT_EN
    localparam int IW = 28;
`else
    localparam int IW = 27;
`endif
    localparam int DIG = 8;
    localparam int LAT = IW + 1;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    binary_to_bcd_converter_if #(.INPUT_WIDTH(IW), .DIGITS(DIG)) intf ();

    binary_to_bcd_converter #(.INPUT_WIDTH(IW), .DIGITS(DIG)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (intf.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Runs one conversion and reports what was observed.
    task automatic run(input logic [IW-1:0] v, output int lat,
                       output logic [31:0] b, output logic o,
                       output logic n, output logic busy);
        @(negedge clock);
        intf.value      = v;
        intf.inputValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        intf.inputValid = 1'b0;
        lat  = 0;
        busy = 1'b1;
        while (!intf.outputValid && lat < 40) begin
            if (intf.inputReady) busy = 1'b0;
            @(negedge clock);
            lat++;
        end
        b = intf.bcd;
        o = intf.overflow;
        n = intf.negative;
    endtask

    task automatic test_reset;
        logic saw;
        reset = 1'b1;
        intf.inputValid = 1'b0;
        intf.value = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (intf.inputReady !== 1'b1 || intf.outputValid !== 1'b0 ||
            intf.bcd !== 32'h0 || intf.overflow !== 1'b0 ||
            intf.negative !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ov=%b bcd=%h of=%b ng=%b exp 1 0 0 0 0",
                     intf.inputReady, intf.outputValid, intf.bcd,
                     intf.overflow, intf.negative);
        end
        reset = 1'b1;
        intf.value = IW'(5);
        intf.inputValid = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        intf.inputValid = 1'b0;
        saw = 1'b0;
        checks++;
        if (intf.inputReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_wins_ready: got %b expected 1", intf.inputReady);
        end
        repeat (LAT + 4) begin
            @(negedge clock);
            if (intf.outputValid) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins_strobe: got %b expected 0", saw);
        end
    endtask

    task automatic test_zero;
        int lat;
        logic [31:0] b;
        logic o, n, busy;
        run('0, lat, b, o, n, busy);
        checks++;
        if (lat !== LAT || b !== 32'h0 || o !== 1'b0) begin
            errors++;
            $display("FAIL zero: lat=%0d bcd=%h of=%b expected %0d 00000000 0",
                     lat, b, o, LAT);
        end
        @(negedge clock);
        checks++;
        if (intf.outputValid !== 1'b0) begin
            errors++;
            $display("FAIL strobe_width: got %b expected 0", intf.outputValid);
        end
    endtask

    task automatic test_basic;
        int lat;
        logic [31:0] b;
        logic o, n, busy, saw;
        run(IW'(12345678), lat, b, o, n, busy);
        checks++;
        if (lat !== LAT || b !== 32'h12345678) begin
            errors++;
            $display("FAIL basic: lat=%0d bcd=%h expected %0d 12345678", lat, b, LAT);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: ready seen, got %b expected 1", busy);
        end
        saw = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (intf.outputValid) saw = 1'b1;
        end
        checks++;
        if (intf.bcd !== 32'h12345678 || saw !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: bcd=%h strobe=%b expected 12345678 0",
                     intf.bcd, saw);
        end
    endtask

    task automatic test_boundary;
        int lat;
        logic [31:0] b;
        logic o, n, busy;
        run(IW'(99999999), lat, b, o, n, busy);
        checks++;
        if (b !== 32'h99999999 || o !== 1'b0 || n !== 1'b0) begin
            errors++;
            $display("FAIL max_in_range: bcd=%h of=%b ng=%b expected 99999999 0 0",
                     b, o, n);
        end
        run(IW'(100000000), lat, b, o, n, busy);
        checks++;
        if (b !== 32'h99999999 || o !== 1'b1 || n !== 1'b0) begin
            errors++;
            $display("FAIL first_overflow: bcd=%h of=%b ng=%b expected 99999999 1 0",
                     b, o, n);
        end
        run(IW'(1010), lat, b, o, n, busy);
        checks++;
        if (b !== 32'h00001010 || o !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clears: bcd=%h of=%b expected 00001010 0", b, o);
        end
`ifndef BCD_SIGNED_INPUT_EN
        run({IW{1'b1}}, lat, b, o, n, busy);
        checks++;
        if (b !== 32'h99999999 || o !== 1'b1 || n !== 1'b0) begin
            errors++;
            $display("FAIL all_ones: bcd=%h of=%b ng=%b expected 99999999 1 0",
                     b, o, n);
        end
`endif
    endtask

    task automatic test_back_to_back;
        int first, second;
        logic [31:0] b1, b2;
        logic busy, rdy;
        @(negedge clock);
        intf.value = IW'(7);
        intf.inputValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        intf.value = IW'(42);
        first = -1;
        second = -1;
        busy = 1'b1;
        rdy = 1'b0;
        b1 = '0;
        b2 = '0;
        for (int k = 0; k < 80; k++) begin
            if (intf.outputValid) begin
                if (first < 0) begin
                    first = k;
                    b1 = intf.bcd;
                end else begin
                    second = k;
                    b2 = intf.bcd;
                end
            end
            if (k < LAT && intf.inputReady) busy = 1'b0;
            if (k == LAT) rdy = intf.inputReady;
            if (k == LAT + 1) intf.inputValid = 1'b0;
            if (second >= 0) break;
            @(negedge clock);
        end
        intf.inputValid = 1'b0;
        checks++;
        if (first !== LAT || b1 !== 32'h7) begin
            errors++;
            $display("FAIL b2b_first: at=%0d bcd=%h expected %0d 00000007",
                     first, b1, LAT);
        end
        checks++;
        if (second !== 2 * LAT + 1 || b2 !== 32'h42) begin
            errors++;
            $display("FAIL b2b_second: at=%0d bcd=%h expected %0d 00000042",
                     second, b2, 2 * LAT + 1);
        end
        checks++;
        if (busy !== 1'b1 || rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: busy=%b rdy=%b expected 1 1", busy, rdy);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [31:0] b;
        logic o, n, busy, saw;
        @(negedge clock);
        intf.value = IW'(55555555);
        intf.inputValid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        intf.inputValid = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (intf.inputReady !== 1'b1 || intf.bcd !== 32'h0 ||
            intf.outputValid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b bcd=%h ov=%b expected 1 00000000 0",
                     intf.inputReady, intf.bcd, intf.outputValid);
        end
        saw = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clock);
            if (intf.outputValid) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_strobe: got %b expected 0", saw);
        end
        run(IW'(305), lat, b, o, n, busy);
        checks++;
        if (lat !== LAT || b !== 32'h00000305 || o !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: lat=%0d bcd=%h of=%b expected %0d 00000305 0",
                     lat, b, o, LAT);
        end
    endtask

`ifdef BCD_SIGNED_INPUT_EN
    task automatic test_signed;
        int lat;
        logic [31:0] b;
        logic o, n, busy;
        logic [IW-1:0] t;
        t = IW'(-1);
        run(t, lat, b, o, n, busy);
        checks++;
        if (b !== 32'h1 || n !== 1'b1 || o !== 1'b0 || lat !== LAT) begin
            errors++;
            $display("FAIL neg_one: bcd=%h ng=%b of=%b lat=%0d expected 00000001 1 0 %0d",
                     b, n, o, lat, LAT);
        end
        t = IW'(-12345678);
        run(t, lat, b, o, n, busy);
        checks++;
        if (b !== 32'h12345678 || n !== 1'b1 || o !== 1'b0) begin
            errors++;
            $display("FAIL neg_big: bcd=%h ng=%b of=%b expected 12345678 1 0", b, n, o);
        end
        t = '0;
        t[IW-1] = 1'b1;
        run(t, lat, b, o, n, busy);
        checks++;
        if (b !== 32'h99999999 || n !== 1'b1 || o !== 1'b1) begin
            errors++;
            $display("FAIL most_neg: bcd=%h ng=%b of=%b expected 99999999 1 1", b, n, o);
        end
        run(IW'(5), lat, b, o, n, busy);
        checks++;
        if (b !== 32'h5 || n !== 1'b0) begin
            errors++;
            $display("FAIL pos_after_neg: bcd=%h ng=%b expected 00000005 0", b, n);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        intf.inputValid = 1'b0;
        intf.value = '0;
        test_reset();
        test_zero();
        test_basic();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
`ifdef BCD_SIGNED_INPUT_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
